// File: rtl/phy_pkg.sv
// Shared PHY constants: lane idle/sync character, TX FSM encoding, bit counter width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package phy_pkg;

    // Comma character sent during sync and on every idle byte slot
    localparam logic [7:0] COM_CHAR = 8'hBC;

    // Transmit FSM encoding
    localparam logic SYNC   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    // Bit position counter within a byte slot (8 bits per byte)
    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/par_serial_tx.sv
// Parallel-to-serial lane transmitter: sends SYNC_WORDS COM bytes after reset, then data or COM fill, MSB first.
// Latency: byte sampled at load edge E; MSB on data_out during E..E+1, LSB during E+7..E+8.
// Backpressure: none; the source must hold data/valid across a load edge, and unsampled bytes are replaced by COM.
module par_serial_tx
    import phy_pkg::*;
#(
    parameter int SYNC_WORDS = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              data_out,
    output logic              tx_active,
    output logic              data_taken
);

    // Value of the sync counter on the final sync byte's load
    localparam logic [3:0] SYNC_CNT_LAST = 4'(SYNC_WORDS - 1);

    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [3:0]           r_sync_cnt;
    logic                 r_state;
    logic [DATA_W-1:0]    r_shift;
    logic                 r_data_out;
    logic                 r_tx_active;
    logic                 r_data_taken;

    logic                 w_load;
    logic [DATA_W-1:0]    w_next_byte;

    // A new byte enters the shifter whenever the bit counter wraps to zero
    assign w_load = (r_bit_cnt == '0);

    // Choose the byte for the next slot: COM while syncing or when nothing valid is offered
    always_comb begin
        w_next_byte = DATA_W'(COM_CHAR);
        if ((r_state == ACTIVE) && valid_in) begin
            w_next_byte = data_in;
        end
    end

    // Bit counter, sync FSM, shift register and registered outputs
    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            r_bit_cnt    <= '0;
            r_sync_cnt   <= '0;
            r_state      <= SYNC;
            r_shift      <= '0;
            r_data_out   <= 1'b0;
            r_tx_active  <= 1'b0;
            r_data_taken <= 1'b0;
        end else begin
            r_bit_cnt    <= r_bit_cnt + BIT_CNT_W'(1);
            r_tx_active  <= (r_state == ACTIVE);
            r_data_taken <= 1'b0;
            if (w_load) begin
                r_shift      <= w_next_byte;
                // MSB goes straight to the lane so the byte has no gap after the previous one
                r_data_out   <= w_next_byte[DATA_W-1];
                r_data_taken <= (r_state == ACTIVE) && valid_in;
                if (r_state == SYNC) begin
                    if (r_sync_cnt == SYNC_CNT_LAST) begin
                        // Counter is left at its final value; ACTIVE is only left via reset
                        r_state <= ACTIVE;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + 4'd1;
                    end
                end
            end else begin
                r_shift    <= r_shift << 1;
                // Bit 6 of the pre-shift register is the next bit after the one already on the lane
                r_data_out <= r_shift[DATA_W-2];
            end
        end
    end

    assign data_out   = r_data_out;
    assign tx_active  = r_tx_active;
    assign data_taken = r_data_taken;

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx against a slot/phase reference model.
// Latency: model predicts outputs one clk_8f edge after inputs are applied.
// Backpressure: n/a.
module tb_par_serial_tx;

    localparam int         SW  = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_8f;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       tx_active;
    logic       data_taken;

    int total;
    int bad;

    // Reference model state: cycles since reset release and the byte currently on the lane
    int         n;
    logic [7:0] cur_byte;
    logic       exp_out;
    logic       exp_act;
    logic       exp_tk;

    par_serial_tx #(
        .SYNC_WORDS (SW),
        .DATA_W     (8)
    ) dut (
        .clk_8f     (clk_8f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .tx_active  (tx_active),
        .data_taken (data_taken)
    );

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    // One clock: apply inputs, advance the model, check all outputs just after the edge
    task automatic tick(input logic rst_n, input logic vld, input logic [7:0] dat, input string tag);
        int phase;
        int slot;
        reset_L  = rst_n;
        valid_in = vld;
        data_in  = dat;
        @(posedge clk_8f);
        if (!rst_n) begin
            exp_out  = 1'b0;
            exp_act  = 1'b0;
            exp_tk   = 1'b0;
            cur_byte = 8'h00;
            n        = 0;
        end else begin
            phase = n % 8;
            slot  = n / 8;
            if (phase == 0) begin
                cur_byte = (slot >= SW && vld) ? dat : COM;
            end
            exp_out = cur_byte[7-phase];
            exp_act = (n >= 8 * (SW - 1) + 1);
            exp_tk  = (phase == 0) && (slot >= SW) && vld;
            n++;
        end
        #1;
        total++;
        assert (data_out === exp_out) else begin
            bad++;
            $error("FAIL %s data_out n=%0d got=%b exp=%b", tag, n, data_out, exp_out);
        end
        total++;
        assert (tx_active === exp_act) else begin
            bad++;
            $error("FAIL %s tx_active n=%0d got=%b exp=%b", tag, n, tx_active, exp_act);
        end
        total++;
        assert (data_taken === exp_tk) else begin
            bad++;
            $error("FAIL %s data_taken n=%0d got=%b exp=%b", tag, n, data_taken, exp_tk);
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rv;
        total    = 0;
        bad      = 0;
        n        = 0;
        cur_byte = 8'h00;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Step 1: reset, then idle; sync pattern, tx_active rise at cycle 25, no data_taken
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, "reset");
        for (int i = 0; i < 48; i++) tick(1'b1, 1'b0, 8'($urandom), "sync_idle");

        // Step 2: single 0xA5 byte held across one load, then idle
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 8'hA5, "byte_a5");
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'h00, "idle_after_a5");

        // Step 3: valid from release; sync bytes ignore it, fifth byte is 0xFF
        tick(1'b0, 1'b1, 8'hFF, "reset2");
        for (int i = 0; i < 48; i++) tick(1'b1, 1'b1, 8'hFF, "valid_in_sync");

        // Step 4: back-to-back 0x00 then 0xFF
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 8'h00, "b2b_00");
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 8'hFF, "b2b_ff");
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'h00, "b2b_idle");

        // Step 5: valid only during bit positions 3..5 is dropped
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom);
            for (int i = 0; i < 8; i++) tick(1'b1, (i >= 3 && i <= 5), rb, "mid_valid");
        end

        // Step 6: reset during bit 3 of 0xA5; remaining bits dropped, sync restarts
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 8'hA5, "pre_abort");
        tick(1'b0, 1'b1, 8'hA5, "abort_reset");
        for (int i = 0; i < 48; i++) tick(1'b1, 1'b1, 8'hA5, "post_abort");

        // Step 7: random slots mixing held bytes, idle slots and data changing mid-slot
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom);
            rv = 1'($urandom);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tick(1'b1, 1'($urandom), 8'($urandom), "rand_noise");
                end else begin
                    tick(1'b1, rv, rb, "rand_slot");
                end
            end
        end

        // Step 8: random reset hit, then recovery
        for (int i = 0; i < $urandom_range(1, 7); i++) tick(1'b1, 1'b1, 8'($urandom), "pre_rand_rst");
        tick(1'b0, 1'b0, 8'h00, "rand_rst");
        for (int i = 0; i < 56; i++) tick(1'b1, 1'($urandom), 8'($urandom), "post_rand_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/par_serial_tx.md
Name: par_serial_tx

Overview:
Transmit-side parallel-to-serial stage. It sits directly downstream of the 2:1 lane mux and consumes its 8-bit data/valid byte stream. It drives one serial lane, MSB first, one bit per clk_8f cycle. After every reset it first sends a fixed run of COM (0xBC) characters so the receiver can lock. From then on it sends COM on every byte slot where no valid byte is offered.

Parameters:
SYNC_WORDS, 4, number of COM bytes forced after reset before valid data is accepted (legal range 1..15)
DATA_W, 8, byte width (fixed at 8; parameter exists for package consistency only)

Ports:
clk_8f  input  1  bit clock; all logic on its rising edge
reset_L  input  1  synchronous, active-low reset
data_in  input  8  byte from the lane mux; the source holds it stable for a full 8-cycle byte slot
valid_in  input  1  data_in qualifier; sampled only on load cycles
data_out  output  1  serial bit, MSB first; registered
tx_active  output  1  high while in ACTIVE state (sync sequence finished)
data_taken  output  1  one-cycle pulse in the cycle after a valid data_in byte was loaded

Behaviour:
- Reset (reset_L=0 at a clk_8f edge): shift_reg=0, bit_cnt=0, sync_cnt=0, state=SYNC, data_out=0, tx_active=0, data_taken=0.
- Reset taken mid-byte aborts that byte immediately; the next cycle data_out=0; the sync sequence restarts from zero.
- bit_cnt is a 3-bit counter, +1 every non-reset cycle, wrapping 7->0.
- Load cycle (bit_cnt==0): shift_reg <= next_byte.
- Other cycles: shift_reg <= shift_reg << 1, zero fill.
- data_out <= next_byte[7] on a load cycle; otherwise data_out <= shift_reg[6]. The 8 bits of a byte appear on data_out in the 8 cycles after its load edge, MSB first, with no gaps between bytes.
- next_byte:
  - SYNC: COM_CHAR, regardless of valid_in.
  - ACTIVE: data_in when valid_in=1, else COM_CHAR.
- Latency: data_in sampled at load edge E; its MSB is on data_out from E to E+1, its LSB from E+7 to E+8.
- valid_in is ignored on all non-load cycles. A valid pulse that does not span a load cycle is dropped and COM is sent instead.
- FSM:
  - SYNC: on each load, sync_cnt += 1.
  - On the load where sync_cnt==SYNC_WORDS-1: state <= ACTIVE and sync_cnt is held.
  - ACTIVE: remains until reset. There is no other exit.
- tx_active is registered and equals (state==ACTIVE). It rises the cycle after the last sync load edge, i.e. it goes high 8*(SYNC_WORDS-1)+1 cycles after the first post-reset edge.
- data_taken <= (load cycle && state==ACTIVE && valid_in). It is 0 in all other cycles and never pulses during SYNC.
- COM inserted in ACTIVE is indistinguishable on the lane from sync COM. The receiver strips it.

Decomposition:
- Shared package phy_pkg holds:
  - COM_CHAR = 8'hBC
  - state encoding (SYNC=1'b0, ACTIVE=1'b1)
  - BIT_CNT_W = 3
- No sub-module. Counter, FSM and shift register stay in one always block plus one combinational next_byte block, about 150 lines.

Test Plan:
1. Reset 3 cycles, release, valid_in=0, SYNC_WORDS=4:
   - data_out repeats 1,0,1,1,1,1,0,0 continuously.
   - tx_active=1 from the 26th cycle after release (cycle 25, counting the first post-release cycle as 0), 0 before.
   - data_taken never pulses.
2. ACTIVE, data_in=0xA5, valid_in=1 held across one load:
   - data_out = 1,0,1,0,0,1,0,1 in the next 8 cycles.
   - data_taken=1 for exactly the cycle after the load.
3. valid_in=1, data_in=0xFF from reset release:
   - first 4 bytes on the lane are 0xBC; data_taken stays 0 during SYNC.
   - 5th byte is 0xFF, with its data_taken pulse.
4. Back-to-back ACTIVE bytes 0x00 then 0xFF:
   - data_out shows 8 zeros then 8 ones with no idle gap.
   - two data_taken pulses 8 cycles apart.
5. valid_in=1 only while bit_cnt is 3..5:
   - byte is not captured; lane carries 0xBC; no data_taken pulse.
6. reset_L=0 for one cycle during bit 3 of 0xA5:
   - next cycle data_out=0, tx_active=0.
   - after release, 4 fresh 0xBC bytes precede any data; remaining A5 bits are never sent.
